// File: rtl/vga_pkg.sv
// Shared timing defaults, scheduler state encoding and a width helper.
// Latency: none (package).
// Backpressure: none (package).
// Port summary: n/a.
package vga_pkg;

   // Default 640x480@60 timing
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_TOTAL   = 800;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_TOTAL   = 525;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } sched_state_t;

   // Counter width for a modulus of n, never less than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into clk_i and emits a one-cycle pulse per rising edge.
// Latency: pulse is visible in the cycle after the 2nd clk_i edge, consumed on the 3rd.
// Backpressure: none; edges closer than two clocks apart may merge.
// Ports: clk_i, rst_ni (async active-low), async_i (raw level), pulse_o (rising-edge pulse).
module sync_edge_detect
   import vga_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic pulse_o
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [2:0] arm_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         arm_q  <= 3'b000;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         arm_q  <= {arm_q[1:0], 1'b1};
      end
   end

   // prev_q only holds a real sample three edges after reset release. Until
   // then a level that was already high would look like a fresh edge, so
   // the pulse is held off.
   assign pulse_o = sync_q & ~prev_q & arm_q[2];

endmodule

// File: rtl/vga_frame_scheduler.sv
// Queues pattern-change requests and commits them only at the start of vertical blanking.
// Latency: active/frame_start 1 cycle after inputs; swap request reaches FSM 3 edges after swap_i rises.
// Backpressure: none; requests arriving while one is pending coalesce into a single advance.
// Ports: clk_i, rst_ni (async active-low), swap_i, horizontal_i/vertical_i (H/V counter),
//        pattern_sel_o, active_o, swap_pending_o, swap_done_o, frame_start_o (all registered).
// Optional: define AUTO_CYCLE_EN to auto-advance every FRAMES_PER_PATTERN frames.
module vga_frame_scheduler #(
   parameter int unsigned H_VISIBLE          = vga_pkg::H_VISIBLE,
   parameter int unsigned H_TOTAL            = vga_pkg::H_TOTAL,
   parameter int unsigned V_VISIBLE          = vga_pkg::V_VISIBLE,
   parameter int unsigned V_TOTAL            = vga_pkg::V_TOTAL,
   parameter int unsigned NUM_PATTERNS       = 4,
   parameter int unsigned FRAMES_PER_PATTERN = 60,
   localparam int unsigned PSEL_W            = vga_pkg::width_of(NUM_PATTERNS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              swap_i,
   input  logic [9:0]        horizontal_i,
   input  logic [9:0]        vertical_i,
   output logic [PSEL_W-1:0] pattern_sel_o,
   output logic              active_o,
   output logic              swap_pending_o,
   output logic              swap_done_o,
   output logic              frame_start_o
);

   import vga_pkg::*;

   localparam logic [9:0]        H_VIS_L   = 10'(H_VISIBLE);
   localparam logic [9:0]        V_VIS_L   = 10'(V_VISIBLE);
   localparam logic [9:0]        H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]        V_LASTVIS = 10'(V_VISIBLE - 1);
   localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [PSEL_W-1:0] PSEL_LAST = PSEL_W'(NUM_PATTERNS - 1);

   if (NUM_PATTERNS < 2 || FRAMES_PER_PATTERN < 1) begin : g_bad_cfg
      $error("vga_frame_scheduler: NUM_PATTERNS must be >= 2 and FRAMES_PER_PATTERN >= 1");
   end

   sched_state_t      state_q, state_d;
   logic [PSEL_W-1:0] pattern_q, pattern_d;
   logic              active_q;
   logic              swap_pending_q;
   logic              swap_done_q;
   logic              frame_start_q;

   logic swap_req;
   logic req;
   logic vblank_evt;
   logic frame_evt;

   sync_edge_detect u_swap_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (swap_i),
      .pulse_o (swap_req)
   );

   // Exact-match decode, so out-of-range counter values never fire an event.
   assign vblank_evt = (horizontal_i == H_LAST) && (vertical_i == V_LASTVIS);
   assign frame_evt  = (horizontal_i == H_LAST) && (vertical_i == V_LAST);

`ifdef AUTO_CYCLE_EN
   localparam int unsigned      FCNT_W    = width_of(FRAMES_PER_PATTERN);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              auto_req;

   // A commit (manual or automatic) restarts the period from zero.
   always_comb begin
      fcnt_d   = fcnt_q;
      auto_req = 1'b0;
      if (swap_done_q) begin
         fcnt_d = '0;
      end else if (frame_evt) begin
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d   = '0;
            auto_req = 1'b1;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign req = swap_req | auto_req;
`else
   assign req = swap_req;
`endif

   // A request seen in IDLE always waits for a later vblank, even when the
   // vblank decode fires in the same cycle. While PENDING, further requests
   // are absorbed. A request during COMMIT re-arms for the next frame.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      unique case (state_q)
         IDLE: begin
            if (req) state_d = PENDING;
         end
         PENDING: begin
            if (vblank_evt) state_d = COMMIT;
         end
         COMMIT: begin
            pattern_d = (pattern_q == PSEL_LAST) ? '0 : pattern_q + 1'b1;
            state_d   = req ? PENDING : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         pattern_q      <= '0;
         active_q       <= 1'b0;
         swap_pending_q <= 1'b0;
         swap_done_q    <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         pattern_q      <= pattern_d;
         active_q       <= (horizontal_i < H_VIS_L) && (vertical_i < V_VIS_L);
         // Both flags trail the state by one cycle, so swap_done lines up
         // with the cycle in which pattern_sel shows its new value.
         swap_pending_q <= (state_q == PENDING);
         swap_done_q    <= (state_q == COMMIT);
         frame_start_q  <= frame_evt;
      end
   end

   assign pattern_sel_o  = pattern_q;
   assign active_o       = active_q;
   assign swap_pending_o = swap_pending_q;
   assign swap_done_o    = swap_done_q;
   assign frame_start_o  = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized and directed stimulus against a request/commit reference model with a scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_vga_frame_scheduler;

   localparam int H_VIS = 16;
   localparam int H_TOT = 20;
   localparam int V_VIS = 6;
   localparam int V_TOT = 8;
   localparam int NP    = 4;
   localparam int FPP   = 2;
   localparam int PW    = $clog2(NP);
   localparam int FRAME = H_TOT * V_TOT;
   localparam int P_VB  = (V_VIS - 1) * H_TOT + (H_TOT - 1);

   typedef struct {
      int pat;
      int due;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          swap;
   logic [9:0]    horizontal;
   logic [9:0]    vertical;
   logic [PW-1:0] pattern_sel;
   logic          active;
   logic          swap_pending;
   logic          swap_done;
   logic          frame_start;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   pos   = 0;
   int   oor_left = 0;

   // reference model state
   int   m_req_q[$];
   int   keep_q[$];
   exp_t sb[$];
   int   m_pat   = 0;
   logic m_pend  = 1'b0;
   int   m_cnt   = 0;
   int   m_clr_edge = -1;
   logic exp_active  = 1'b0;
   logic exp_fs      = 1'b0;
   logic exp_pending = 1'b0;
   int   mon_pat = 0;

   vga_frame_scheduler #(
      .H_VISIBLE          (H_VIS),
      .H_TOTAL            (H_TOT),
      .V_VISIBLE          (V_VIS),
      .V_TOTAL            (V_TOT),
      .NUM_PATTERNS       (NP),
      .FRAMES_PER_PATTERN (FPP)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .swap_i         (swap),
      .horizontal_i   (horizontal),
      .vertical_i     (vertical),
      .pattern_sel_o  (pattern_sel),
      .active_o       (active),
      .swap_pending_o (swap_pending),
      .swap_done_o    (swap_done),
      .frame_start_o  (frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a request counts for the first vblank strictly after
   // the edge it arrives on; every request up to and including that vblank
   // edge is absorbed into the one advance.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_req_q.delete();
            sb.delete();
            m_pat      = 0;
            m_pend     = 1'b0;
            m_cnt      = 0;
            m_clr_edge = -1;
            exp_active  = 1'b0;
            exp_fs      = 1'b0;
            exp_pending = 1'b0;
         end else begin
            int  h;
            int  v;
            logic vb;
            logic commit;
            h = int'(horizontal);
            v = int'(vertical);
            vb = (h == H_TOT - 1) && (v == V_VIS - 1);
            exp_active  = (h < H_VIS) && (v < V_VIS);
            exp_fs      = (h == H_TOT - 1) && (v == V_TOT - 1);
            exp_pending = m_pend;
`ifdef AUTO_CYCLE_EN
            if (cyc == m_clr_edge) begin
               m_cnt = 0;
            end else if (exp_fs) begin
               if (m_cnt == FPP - 1) begin
                  m_cnt = 0;
                  m_req_q.push_back(cyc);
               end else begin
                  m_cnt++;
               end
            end
`endif
            commit = 1'b0;
            if (vb) begin
               foreach (m_req_q[i]) if (m_req_q[i] < cyc) commit = 1'b1;
            end
            if (commit) begin
               m_pat = (m_pat + 1) % NP;
               sb.push_back('{pat: m_pat, due: cyc + 1});
               m_clr_edge = cyc + 2;
               keep_q.delete();
               foreach (m_req_q[i]) if (m_req_q[i] > cyc) keep_q.push_back(m_req_q[i]);
               m_req_q = keep_q;
            end
            m_pend = 1'b0;
            foreach (m_req_q[i]) if (m_req_q[i] <= cyc) m_pend = 1'b1;
         end
      end
   end

   // Monitor: compares every cycle, pops the scoreboard on swap_done.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            chk("rst_pattern_sel", int'(pattern_sel), 0);
            chk("rst_active", int'(active), 0);
            chk("rst_swap_pending", int'(swap_pending), 0);
            chk("rst_swap_done", int'(swap_done), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            mon_pat = 0;
         end else begin
            chk("active", int'(active), int'(exp_active));
            chk("frame_start", int'(frame_start), int'(exp_fs));
            chk("swap_pending", int'(swap_pending), int'(exp_pending));
            if (swap_done) begin
               if (sb.size() == 0) begin
                  chk("swap_done_spurious", int'(swap_done), 0);
               end else begin
                  exp_t e0;
                  e0 = sb.pop_front();
                  chk("swap_done_cycle", cyc, e0.due);
                  chk("pattern_sel", int'(pattern_sel), e0.pat);
                  mon_pat = e0.pat;
               end
            end else begin
               chk("pattern_hold", int'(pattern_sel), mon_pat);
               if (sb.size() > 0 && sb[0].due < cyc) begin
                  chk("swap_done_missing", int'(swap_done), 1);
                  mon_pat = sb[0].pat;
                  sb.delete(0);
               end
            end
         end
      end
   end

   // One clock of the H/V counter; values driven now are sampled at edge cyc+1.
   task automatic tick();
      @(negedge clk);
      pos = (pos + 1) % FRAME;
      horizontal = 10'(pos % H_TOT);
      vertical   = 10'(pos / H_TOT);
      if (oor_left > 0) begin
         if ($urandom_range(0, 1) == 0) horizontal = 10'(H_TOT + $urandom_range(0, 200));
         else                           vertical   = 10'(V_TOT + $urandom_range(0, 200));
         oor_left--;
      end
   endtask

   task automatic wait_pos(input int p);
      tick();
      while (pos != p) tick();
   endtask

   // Rising edge of swap now becomes a request on edge cyc+3.
   task automatic pulse(input int hold);
      if (!swap) m_req_q.push_back(cyc + 3);
      swap = 1'b1;
      repeat (hold) tick();
      swap = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      swap       = 1'b0;
      horizontal = '0;
      vertical   = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();

      // single request mid-frame, held 5 cycles
      wait_pos(2 * H_TOT + 5);
      pulse(5);
      wait_pos(P_VB + 5);

      // four requests in separate frames, walks through the wrap
      for (int i = 0; i < 4; i++) begin
         wait_pos(30);
         pulse(3);
         wait_pos(P_VB + 5);
      end

      // three requests inside one frame coalesce
      wait_pos(20);
      pulse(2);
      repeat (3) tick();
      pulse(1);
      repeat (4) tick();
      pulse(3);
      wait_pos(P_VB + 5);

      // request lands on the vblank edge: commits one frame later
      wait_pos(P_VB - 2);
      pulse(2);
      wait_pos(P_VB + 5);
      wait_pos(P_VB + 5);

      // request lands in the COMMIT cycle: re-pends for the next frame
      wait_pos(40);
      pulse(2);
      wait_pos(P_VB - 1);
      pulse(2);
      wait_pos(P_VB + 5);
      wait_pos(P_VB + 5);

      // mid-frame reset with swap held high: no request after release
      repeat (FRAME) tick();
      wait_pos(50);
      swap  = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      swap = 1'b0;
      repeat (FRAME) tick();

      // random requests with occasional out-of-range counter values
      for (int i = 0; i < 250; i++) begin
         repeat ($urandom_range(1, 40)) tick();
         if ($urandom_range(0, 9) == 0) oor_left = $urandom_range(1, 6);
         pulse($urandom_range(1, 5));
      end

      repeat (2 * FRAME) tick();
      wait_pos(10);
      chk("scoreboard_drain", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
Sequences pattern changes for the VGA colour datapath so a change never tears mid-frame. It takes the raw `swap` button/strobe and the horizontal/vertical counters from the H/V counter. It queues the request and commits a new pattern index only at the start of vertical blanking. The colour generator consumes `pattern_sel` and `active`.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_TOTAL, 800, total clocks per line (counter wraps at H_TOTAL-1)
V_VISIBLE, 480, visible lines per frame
V_TOTAL, 525, total lines per frame
NUM_PATTERNS, 4, number of selectable patterns (>=2)
FRAMES_PER_PATTERN, 60, auto-advance period in frames (used only with AUTO_CYCLE_EN)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
swap  in  1  asynchronous swap request, level; a rising edge is one request
horizontal  in  10  current pixel column from H/V counter
vertical  in  10  current line from H/V counter
pattern_sel  out  $clog2(NUM_PATTERNS)  committed pattern index, registered
active  out  1  visible-area flag, registered
swap_pending  out  1  high while a request waits for blanking
swap_done  out  1  one-cycle pulse on the cycle pattern_sel changes
frame_start  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset (reset=0, async): state IDLE; pattern_sel=0, active=0, swap_pending=0, swap_done=0, frame_start=0; synchroniser flops and frame counter cleared.
- Reset release is synchronous to clk: first state update occurs on the first rising edge with reset=1.
- swap passes through a 2-flop synchroniser plus an edge-detect flop.
- A rising edge produces `req` (one cycle) 3 clk edges after swap rises. Pulses shorter than one clk are not guaranteed.
- Events, decoded combinationally from the inputs and registered into outputs:
  - vblank_evt = (horizontal==H_TOTAL-1 && vertical==V_VISIBLE-1)
  - frame_evt = (horizontal==H_TOTAL-1 && vertical==V_TOTAL-1)
- Outputs with 1-cycle latency from the inputs:
  - active <= (horizontal<H_VISIBLE && vertical<V_VISIBLE)
  - frame_start <= frame_evt
- State machine:
  - IDLE: req -> PENDING.
  - PENDING: swap_pending=1. Additional req edges coalesce (no extra advance). vblank_evt -> COMMIT.
  - COMMIT (exactly 1 cycle):
    - pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1 (wrap).
    - swap_done=1 (registered, high during the cycle following COMMIT entry).
    - Next state: PENDING if req is present this cycle, else IDLE.
- req and vblank_evt in the same cycle while IDLE: go to PENDING. The commit occurs at the NEXT frame's vblank, so a request is never committed with zero wait.
- swap_pending is registered: high from the cycle after entering PENDING until the cycle after leaving it.
- Counter values outside range (horizontal>=H_TOTAL) generate no events; no lock-up.
- pattern_sel never changes outside COMMIT.

Optional Feature:
Macro AUTO_CYCLE_EN.
- Defined:
  - A frame counter of width $clog2(FRAMES_PER_PATTERN) increments on frame_evt.
  - On frame_evt with count==FRAMES_PER_PATTERN-1 it wraps to 0 and raises an internal auto_req, OR-ed with req.
  - A manual and an auto request in the same pending window yield one advance.
  - swap_done resets the frame counter to 0.
- Undefined: no frame counter; only swap advances pattern_sel.

Decomposition:
- Package vga_pkg holds:
  - default timing constants H_VISIBLE/H_TOTAL/V_VISIBLE/V_TOTAL;
  - the typedef enum logic [1:0] {IDLE, PENDING, COMMIT} sched_state_t.
- One sub-module: sync_edge_detect (2-flop synchroniser + rising-edge pulse, parameter-free, clk/reset active-low async).

Test Plan:
- Reset held low 2 cycles mid-frame with swap=1 -> all outputs 0, pattern_sel=0; after release no request (level, not edge) is generated.
- swap rises at h=100,v=10 for 5 cycles -> swap_pending high 4 cycles later. At h=799,v=479, COMMIT; swap_done pulses one cycle; pattern_sel 0->1.
- Four requests, each in separate frames -> pattern_sel sequence 1,2,3,0 (wrap at NUM_PATTERNS=4).
- Three swap pulses within one frame before vblank -> single advance, one swap_done.
- req arriving in the same cycle as vblank_evt -> stays PENDING, commits at following frame's v=479,h=799. A req during COMMIT -> returns to PENDING, commits one frame later.
- AUTO_CYCLE_EN with FRAMES_PER_PATTERN=2, no swap -> pattern_sel advances once every 2 frames. A manual swap mid-period resets the count (next auto advance 2 frames after swap_done).
